blur_stream: RTL

Streaming 3x3 blur filter for raster grayscale frames. It replaces the window-fed combinational blur with a block that holds its own line buffers, so it accepts one pixel per handshake instead of nine. It emits the valid-region result, (IMG_W-2) x (IMG_H-2) pixels, with the output window top-left at input (i, j). It sits between the grayscale converter and the frame writer, and selects box or Gaussian kernel per frame.

---
 rtl/blur_pkg.sv | 21 ++
 rtl/line_buf.sv | 31 +++
 rtl/blur_stream.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/blur_pkg.sv
// Shared constants and arithmetic helpers for the streaming 3x3 blur.
// Box divide uses a reciprocal multiply where it is exact, otherwise a true divide.
package blur_pkg;

  localparam logic MODE_BOX   = 1'b0;
  localparam logic MODE_GAUSS = 1'b1;

  localparam int unsigned BOX_RECIP = 3641;
  localparam int unsigned BOX_SHIFT = 15;

  function automatic int unsigned sum_width(input int unsigned dw);
    return dw + 4;
  endfunction

  // 3641/2^15 overshoots 1/9 by 1/294912, so floor stays exact for sums below 32768 (DW <= 8).
  function automatic int unsigned box_div(input int unsigned sum, input int unsigned dw);
    if (dw <= 8) return (sum * BOX_RECIP) >> BOX_SHIFT;
    return sum / 9;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Circular line delay of DEPTH accepted pixels: reads the oldest entry, then overwrites it.
module line_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 300
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_addr;

  assign o_data = r_mem[r_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) r_mem[r_addr] <= i_data;
  end

endmodule

// File: rtl/blur_stream.sv
// Streaming 3x3 blur with internal line buffers; box or Gaussian kernel latched per frame.
// Window registers feed a sum stage, then a divide/shift stage into the output register.
module blur_stream
  import blur_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 300,
  parameter int unsigned IMG_H = 400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_eol,
  output logic          m_last
);
  localparam int unsigned SW = sum_width(DW);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic          w_en, w_acc;
  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic          w_win_ok, w_eol, w_last;
  logic          r_kern;
  logic [DW-1:0] w_lb_r1, w_lb_r2;
  logic [DW-1:0] r_win [3][3];
  logic [SW-1:0] w_box, w_gauss, r_sum;
  logic [DW-1:0] w_div;
  logic          r_v0, r_e0, r_l0, r_k0;
  logic          r_v1, r_e1, r_l1, r_k1;
  logic          r_out_valid, r_out_eol, r_out_last;
  logic [DW-1:0] r_out_data;

  assign w_en    = ~r_out_valid | m_ready;
  assign w_acc   = s_valid & w_en;
  assign s_ready = w_en;

  assign m_valid = r_out_valid;
  assign m_data  = r_out_data;
  assign m_eol   = r_out_eol;
  assign m_last  = r_out_last;

  // A start-of-frame pixel is (0,0) regardless of where the counters stand.
  assign w_col = s_sof ? '0 : r_col;
  assign w_row = s_sof ? '0 : r_row;

  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == CW'(IMG_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == RW'(IMG_H - 1)) ? '0 : w_row + RW'(1);
    end
  end

  assign w_win_ok = (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_eol    = (w_col == CW'(IMG_W - 1));
  assign w_last   = w_eol && (w_row == RW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_kern <= MODE_BOX;
    end else if (w_acc) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      if (w_col == '0 && w_row == '0) r_kern <= mode;
    end
  end

  line_buf #(
    .DW    (DW),
    .DEPTH (IMG_W)
  ) u_lb_r1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_acc),
    .i_data (s_data),
    .o_data (w_lb_r1)
  );

  line_buf #(
    .DW    (DW),
    .DEPTH (IMG_W)
  ) u_lb_r2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_acc),
    .i_data (w_lb_r1),
    .o_data (w_lb_r2)
  );

  // Row 0 is the oldest line, column 2 the newest pixel.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb_r2;
      r_win[1][2] <= w_lb_r1;
      r_win[2][2] <= s_data;
    end
  end

  always_comb begin
    w_box   = '0;
    w_gauss = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_box   = w_box + SW'(r_win[r][c]);
        w_gauss = w_gauss + (SW'(r_win[r][c]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
      end
    end
  end

  always_comb begin
    if (r_k1 == MODE_GAUSS) w_div = DW'(r_sum >> 4);
    else                    w_div = DW'(box_div(32'(r_sum), DW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0        <= 1'b0;
      r_e0        <= 1'b0;
      r_l0        <= 1'b0;
      r_k0        <= MODE_BOX;
      r_v1        <= 1'b0;
      r_e1        <= 1'b0;
      r_l1        <= 1'b0;
      r_k1        <= MODE_BOX;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eol   <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_en) begin
      r_v0        <= w_acc & w_win_ok;
      r_e0        <= w_eol;
      r_l0        <= w_last;
      r_k0        <= r_kern;
      r_v1        <= r_v0;
      r_e1        <= r_e0;
      r_l1        <= r_l0;
      r_k1        <= r_k0;
      r_sum       <= (r_k0 == MODE_GAUSS) ? w_gauss : w_box;
      r_out_valid <= r_v1;
      r_out_data  <= w_div;
      r_out_eol   <= r_v1 & r_e1;
      r_out_last  <= r_v1 & r_l1;
    end
  end

endmodule
